// File: rtl/core_bus_arbiter.sv
// Arbitrates NUM_CH requester channels onto one Wishbone classic master port.
// Each transaction completes with a one-cycle grant carrying read data and an error flag.
module core_bus_arbiter #(
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ROUND_ROBIN    = 1
) (
    input  logic                         i_CLK,
    input  logic                         i_RST,
    input  logic [NUM_CH-1:0]            i_CH_REQ,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] i_CH_ADDR,
    input  logic [NUM_CH*32-1:0]         i_CH_WDATA,
    input  logic [NUM_CH-1:0]            i_CH_WE,
    input  logic [NUM_CH*2-1:0]          i_CH_HB,
    output logic [NUM_CH-1:0]            o_CH_GNT,
    output logic [31:0]                  o_CH_RDATA,
    output logic                         o_CH_ERR,
    output logic [ADDR_WIDTH-1:0]        o_ADDR,
    output logic [31:0]                  o_DATA,
    output logic                         o_WE,
    output logic [3:0]                   o_SEL,
    output logic                         o_STB,
    output logic                         o_CYC,
    input  logic [31:0]                  i_DATA,
    input  logic                         i_ACK,
    input  logic                         i_ERR
);

    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    cyc_q;
    logic                    we_q;
    logic [3:0]              sel_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             data_q;
    logic [NUM_CH-1:0]       gnt_q;
    logic [31:0]             rdata_q;
    logic                    err_q;
    logic [TO_W-1:0]         to_cnt_q;
    logic [CH_W-1:0]         rr_ptr_q;
    logic [CH_W-1:0]         idx_q;
    logic [1:0]              addr_lo_q;
    logic [1:0]              hb_q;

    logic                    win_vld_d;
    logic [CH_W-1:0]         win_idx_d;
    logic [CH_W-1:0]         cand_d;
    logic [ADDR_WIDTH-1:0]   sel_addr_d;
    logic [31:0]             sel_wdata_d;
    logic                    sel_we_d;
    logic [1:0]              sel_hb_d;
    logic                    bad_d;
    logic [3:0]              be_d;
    logic [31:0]             lanes_d;
    logic [31:0]             rd_shift_d;
    logic [31:0]             rd_ext_d;
    logic                    timeout_d;

    // Winner search: rotating start after the last grant, or lowest index first.
    always_comb begin
        win_vld_d = 1'b0;
        win_idx_d = '0;
        cand_d    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ROUND_ROBIN != 0) begin
                cand_d = CH_W'((32'(rr_ptr_q) + i + 1) % NUM_CH);
            end else begin
                cand_d = CH_W'(i);
            end
            if (!win_vld_d && i_CH_REQ[cand_d]) begin
                win_vld_d = 1'b1;
                win_idx_d = cand_d;
            end
        end
    end

    always_comb begin
        sel_addr_d  = '0;
        sel_wdata_d = '0;
        sel_we_d    = 1'b0;
        sel_hb_d    = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (win_idx_d == CH_W'(k)) begin
                sel_addr_d  = i_CH_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata_d = i_CH_WDATA[k*32 +: 32];
                sel_we_d    = i_CH_WE[k];
                sel_hb_d    = i_CH_HB[k*2 +: 2];
            end
        end
    end

    // Byte-lane decode and alignment check for the selected request.
    always_comb begin
        bad_d   = 1'b0;
        be_d    = 4'b0000;
        lanes_d = sel_wdata_d;
        case (sel_hb_d)
            2'b00: begin
                be_d    = 4'b0001 << sel_addr_d[1:0];
                lanes_d = {4{sel_wdata_d[7:0]}};
            end
            2'b01: begin
                bad_d   = sel_addr_d[0];
                be_d    = sel_addr_d[1] ? 4'b1100 : 4'b0011;
                lanes_d = {2{sel_wdata_d[15:0]}};
            end
            2'b10: begin
                bad_d = (sel_addr_d[1:0] != 2'b00);
                be_d  = 4'b1111;
            end
            default: bad_d = 1'b1;
        endcase
    end

    always_comb begin
        rd_shift_d = i_DATA >> {addr_lo_q, 3'b000};
        case (hb_q)
            2'b00:   rd_ext_d = {24'h000000, rd_shift_d[7:0]};
            2'b01:   rd_ext_d = {16'h0000, rd_shift_d[15:0]};
            default: rd_ext_d = rd_shift_d;
        endcase
    end

    assign timeout_d = (TIMEOUT_CYCLES != 0) && (to_cnt_q == TO_W'(TO_LAST));

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q   <= IDLE;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            gnt_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            to_cnt_q  <= '0;
            rr_ptr_q  <= CH_W'(NUM_CH - 1);
            idx_q     <= '0;
            addr_lo_q <= '0;
            hb_q      <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (win_vld_d) begin
                        idx_q     <= win_idx_d;
                        rr_ptr_q  <= win_idx_d;
                        addr_lo_q <= sel_addr_d[1:0];
                        hb_q      <= sel_hb_d;
                        addr_q    <= {sel_addr_d[ADDR_WIDTH-1:2], 2'b00};
                        data_q    <= lanes_d;
                        if (bad_d) begin
                            // Illegal size/alignment never reaches the bus.
                            state_q <= DONE;
                            gnt_q   <= NUM_CH'(1) << win_idx_d;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end else begin
                            state_q  <= BUS;
                            cyc_q    <= 1'b1;
                            we_q     <= sel_we_d;
                            sel_q    <= be_d;
                            to_cnt_q <= '0;
                        end
                    end
                end
                BUS: begin
                    if (i_ERR || i_ACK || timeout_d) begin
                        state_q <= DONE;
                        cyc_q   <= 1'b0;
                        we_q    <= 1'b0;
                        sel_q   <= '0;
                        gnt_q   <= NUM_CH'(1) << idx_q;
                        err_q   <= i_ERR || !i_ACK;
                        rdata_q <= (i_ACK && !i_ERR) ? rd_ext_d : 32'h0;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_CYC      = cyc_q;
    assign o_STB      = cyc_q;
    assign o_WE       = we_q;
    assign o_SEL      = sel_q;
    assign o_ADDR     = addr_q;
    assign o_DATA     = data_q;
    assign o_CH_GNT   = gnt_q;
    assign o_CH_RDATA = rdata_q;
    assign o_CH_ERR   = err_q;

endmodule
